// File: rtl/tblink_rpc_ep_pkg.sv
// Shared types and constants for the tblink RPC network endpoint.
// Optional feature macro: TBLINK_RPC_EP_BCAST_EN (broadcast delivery of address 8'hFF).
package tblink_rpc_ep_pkg;

    localparam int unsigned HDR_DST_OFS = 0;
    localparam int unsigned HDR_LEN_OFS = 1;
    localparam logic [7:0]  BCAST_ADDR  = 8'hFF;

    localparam int OUT_TIP = 0;
    localparam int OUT_NET = 1;

    // Header states are numbered by the byte offset they expect next.
    typedef enum logic [1:0] {
        HDR_DST = 2'(HDR_DST_OFS),
        HDR_LEN = 2'(HDR_LEN_OFS),
        PAYLOAD = 2'd2
    } trk_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_NET  = 2'd1,
        OWN_TIP  = 2'd2
    } neto_owner_e;

endpackage

// File: rtl/tblink_rpc_ep_pkt_trk.sv
// Packet boundary tracker for one byte stream: flags the first byte and the last byte.
// state   | meaning
// HDR_DST | next byte is the destination address (start of packet)
// HDR_LEN | next byte is the payload length
// PAYLOAD | payload bytes remain; cnt_q holds how many
module tblink_rpc_ep_pkt_trk
    import tblink_rpc_ep_pkg::*;
(
    input  logic       uclock,
    input  logic       reset,
    input  logic       xfer,
    input  logic [7:0] dat,
    output logic       sop,
    output logic       eop
);

    trk_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge uclock or negedge reset) begin
        if (!reset) begin
            state_q <= HDR_DST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eop     = 1'b0;
        case (state_q)
            HDR_DST: begin
                if (xfer) state_d = HDR_LEN;
            end
            HDR_LEN: begin
                eop = (dat == 8'd0);
                if (xfer) begin
                    cnt_d   = dat;
                    state_d = (dat == 8'd0) ? HDR_DST : PAYLOAD;
                end
            end
            PAYLOAD: begin
                eop = (cnt_q == 8'd1);
                if (xfer) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = HDR_DST;
                end
            end
            default: state_d = HDR_DST;
        endcase
    end

    assign sop = (state_q == HDR_DST);

endmodule

// File: rtl/tblink_rpc_ep.sv
// tblink RPC endpoint: routes ingress packets to the local TIP or onward, merges TIP traffic onto the network.
// Optional feature macro: TBLINK_RPC_EP_BCAST_EN (address 8'hFF goes to both the TIP and the network).
module tblink_rpc_ep
    import tblink_rpc_ep_pkg::*;
#(
    parameter logic [7:0] ADDR = 8'h00
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic       hreq_i,
    output logic       hreq_o,
    input  logic [7:0] neti_dat,
    input  logic       neti_valid,
    output logic       neti_ready,
    output logic [7:0] neto_dat,
    output logic       neto_valid,
    input  logic       neto_ready,
    output logic [7:0] tipo_dat,
    output logic       tipo_valid,
    input  logic       tipo_ready,
    input  logic [7:0] tipi_dat,
    input  logic       tipi_valid,
    output logic       tipi_ready
);

    logic [1:0][1:0][7:0] mem_q;
    logic [1:0]           rd_q;
    logic [1:0][1:0]      cnt_q;
    logic [1:0]           wr, pop, space;
    logic [1:0][7:0]      wr_dat;

    neto_owner_e owner_q, owner_d;
    logic        prio_tip_q, prio_tip_d;
    logic        rt_tip_q, rt_net_q;
    logic        rdy_en_q, stall_q, stall;
    logic        n_sop, n_eop, t_sop, t_eop, n_xfer, t_xfer;
    logic        hit_tip, hit_net, route_tip, route_net;
    logic        net_req, tip_req, new_net, new_tip;

    tblink_rpc_ep_pkt_trk u_trk_neti (
        .uclock (uclock),
        .reset  (reset),
        .xfer   (n_xfer),
        .dat    (neti_dat),
        .sop    (n_sop),
        .eop    (n_eop)
    );

    tblink_rpc_ep_pkt_trk u_trk_tipi (
        .uclock (uclock),
        .reset  (reset),
        .xfer   (t_xfer),
        .dat    (tipi_dat),
        .sop    (t_sop),
        .eop    (t_eop)
    );

    // Two-entry output buffers; ready upstream is simply "not full" to keep paths short.
    always_ff @(posedge uclock or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr[i]) mem_q[i][rd_q[i] ^ cnt_q[i][0]] <= wr_dat[i];
                if (pop[i]) rd_q[i] <= ~rd_q[i];
                cnt_q[i] <= cnt_q[i] + {1'b0, wr[i]} - {1'b0, pop[i]};
            end
        end
    end

    assign space[OUT_TIP] = (cnt_q[OUT_TIP] != 2'd2);
    assign space[OUT_NET] = (cnt_q[OUT_NET] != 2'd2);
    assign tipo_valid     = (cnt_q[OUT_TIP] != 2'd0);
    assign neto_valid     = (cnt_q[OUT_NET] != 2'd0);
    assign tipo_dat       = mem_q[OUT_TIP][rd_q[OUT_TIP]];
    assign neto_dat       = mem_q[OUT_NET][rd_q[OUT_NET]];
    assign pop[OUT_TIP]   = tipo_valid & tipo_ready;
    assign pop[OUT_NET]   = neto_valid & neto_ready;
    assign stall          = tipo_valid & ~tipo_ready;

    always_comb begin
`ifdef TBLINK_RPC_EP_BCAST_EN
        hit_tip = (neti_dat == ADDR) || (neti_dat == BCAST_ADDR);
        hit_net = (neti_dat != ADDR) || (neti_dat == BCAST_ADDR);
`else
        hit_tip = (neti_dat == ADDR);
        hit_net = !hit_tip;
`endif
        route_tip = n_sop ? hit_tip : rt_tip_q;
        route_net = n_sop ? hit_net : rt_net_q;

        // neto is granted per packet; a tipi packet that lost once wins the next boundary.
        net_req = neti_valid && n_sop && hit_net;
        tip_req = tipi_valid && t_sop && !hreq_i;
        new_net = (owner_q == OWN_NONE) && net_req && !(tip_req && prio_tip_q);
        new_tip = (owner_q == OWN_NONE) && tip_req && !new_net;

        neti_ready = rdy_en_q && (!route_tip || space[OUT_TIP])
                     && (!route_net || (((owner_q == OWN_NET) || new_net) && space[OUT_NET]));
        tipi_ready = rdy_en_q && space[OUT_NET] && ((owner_q == OWN_TIP) || new_tip);

        n_xfer = neti_valid && neti_ready;
        t_xfer = tipi_valid && tipi_ready;

        wr[OUT_TIP]     = n_xfer && route_tip;
        wr[OUT_NET]     = (n_xfer && route_net) || t_xfer;
        wr_dat[OUT_TIP] = neti_dat;
        wr_dat[OUT_NET] = t_xfer ? tipi_dat : neti_dat;

        owner_d    = owner_q;
        prio_tip_d = prio_tip_q;
        if ((n_xfer && route_net && n_eop) || (t_xfer && t_eop)) begin
            owner_d = OWN_NONE;
        end else if (n_xfer && new_net) begin
            owner_d = OWN_NET;
        end else if (t_xfer && new_tip) begin
            owner_d = OWN_TIP;
        end
        if (n_xfer && new_net && tip_req) begin
            prio_tip_d = 1'b1;
        end else if (t_xfer && new_tip) begin
            prio_tip_d = 1'b0;
        end
    end

    always_ff @(posedge uclock or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            prio_tip_q <= 1'b0;
            rt_tip_q   <= 1'b0;
            rt_net_q   <= 1'b0;
            rdy_en_q   <= 1'b0;
            stall_q    <= 1'b0;
            hreq_o     <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            prio_tip_q <= prio_tip_d;
            rdy_en_q   <= 1'b1;
            stall_q    <= stall;
            hreq_o     <= hreq_i | (stall & stall_q);
            if (n_xfer && n_sop) begin
                rt_tip_q <= hit_tip;
                rt_net_q <= hit_net;
            end
        end
    end

endmodule

// File: tb/tb_tblink_rpc_ep.sv
// Self-checking bench for tblink_rpc_ep: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_tblink_rpc_ep;

    localparam logic [7:0] ADDR = 8'h01;
    localparam int         TMO  = 400;

    logic       uclock = 1'b0;
    logic       reset = 1'b0;
    logic       hreq_i = 1'b0;
    logic       hreq_o;
    logic [7:0] neti_dat = 8'h00;
    logic       neti_valid = 1'b0;
    logic       neti_ready;
    logic [7:0] neto_dat;
    logic       neto_valid;
    logic       neto_ready = 1'b1;
    logic [7:0] tipo_dat;
    logic       tipo_valid;
    logic       tipo_ready = 1'b1;
    logic [7:0] tipi_dat = 8'h00;
    logic       tipi_valid = 1'b0;
    logic       tipi_ready;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rnd_done = 1'b0;

    logic [7:0] tipo_q[$];
    logic [7:0] neto_q[$];
    int tipo_cyc[$];
    int neto_cyc[$];
    int neti_cyc[$];
    int tipi_cyc[$];

    always #5 uclock = ~uclock;

    tblink_rpc_ep #(.ADDR(ADDR)) dut (
        .uclock     (uclock),
        .reset      (reset),
        .hreq_i     (hreq_i),
        .hreq_o     (hreq_o),
        .neti_dat   (neti_dat),
        .neti_valid (neti_valid),
        .neti_ready (neti_ready),
        .neto_dat   (neto_dat),
        .neto_valid (neto_valid),
        .neto_ready (neto_ready),
        .tipo_dat   (tipo_dat),
        .tipo_valid (tipo_valid),
        .tipo_ready (tipo_ready),
        .tipi_dat   (tipi_dat),
        .tipi_valid (tipi_valid),
        .tipi_ready (tipi_ready)
    );

    // Handshakes are observed mid-cycle; inputs only change just after the rising edge.
    always @(negedge uclock) begin
        cyc++;
        if (reset) begin
            if (tipo_valid && tipo_ready) begin tipo_q.push_back(tipo_dat); tipo_cyc.push_back(cyc); end
            if (neto_valid && neto_ready) begin neto_q.push_back(neto_dat); neto_cyc.push_back(cyc); end
            if (neti_valid && neti_ready) neti_cyc.push_back(cyc);
            if (tipi_valid && tipi_ready) tipi_cyc.push_back(cyc);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack8(input logic [7:0] q[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size() && i < 8; i++) v = {v[55:0], q[i]};
        return v;
    endfunction

    task automatic clear_mon;
        tipo_q.delete(); neto_q.delete();
        tipo_cyc.delete(); neto_cyc.delete(); neti_cyc.delete(); tipi_cyc.delete();
    endtask

    task automatic drive_pkt(input bit on_tipi, input logic [7:0] pkt[$], input int gap);
        for (int i = 0; i < pkt.size(); i++) begin
            int w;
            int k;
            k = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            if (k > 0) begin
                if (on_tipi) tipi_valid = 1'b0; else neti_valid = 1'b0;
                repeat (k) @(posedge uclock);
                #1;
            end
            if (on_tipi) begin tipi_valid = 1'b1; tipi_dat = pkt[i]; end
            else begin neti_valid = 1'b1; neti_dat = pkt[i]; end
            w = 0;
            @(negedge uclock);
            while (!(on_tipi ? tipi_ready : neti_ready) && w < TMO) begin
                @(negedge uclock);
                w++;
            end
            @(posedge uclock);
            #1;
            if (w >= TMO) begin
                n_checks++; n_fail++;
                $display("FAIL %s_drive_timeout: byte %0d ready=0, required 1 within %0d cycles",
                         on_tipi ? "tipi" : "neti", i, TMO);
                break;
            end
        end
        if (on_tipi) tipi_valid = 1'b0; else neti_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n_tipo, input int n_neto);
        int w = 0;
        while ((tipo_q.size() < n_tipo || neto_q.size() < n_neto) && w < TMO) begin
            @(posedge uclock);
            w++;
        end
        repeat (3) @(posedge uclock);
        #1;
        n_checks++;
        if (w >= TMO) begin
            n_fail++;
            $display("FAIL drain_timeout: got tipo=%0d neto=%0d bytes, required %0d/%0d",
                     tipo_q.size(), neto_q.size(), n_tipo, n_neto);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        neti_dat = ADDR;
        repeat (3) @(posedge uclock);
        @(negedge uclock);
        n_checks++;
        if ({neti_ready, tipi_ready, neto_valid, tipo_valid, hreq_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {neti_ready, tipi_ready, neto_valid, tipo_valid, hreq_o});
        end
        @(posedge uclock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (neti_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge: neti_ready=%b, required 0", neti_ready);
        end
        @(posedge uclock);
        #1;
        n_checks++;
        if (neti_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_edge: neti_ready=%b, required 1", neti_ready);
        end
    endtask

    task automatic test_local;
        logic [7:0] p[$];
        clear_mon();
        p = {8'h01, 8'h02, 8'hAA, 8'hBB};
        drive_pkt(1'b0, p, 0);
        wait_drain(4, 0);
        n_checks++;
        if (tipo_q.size() != 4 || pack8(tipo_q) !== 64'h0102_AABB) begin
            n_fail++; $display("FAIL local_tipo: got %0d bytes %h, required 4 bytes 0102aabb", tipo_q.size(), pack8(tipo_q));
        end
        n_checks++;
        if (neto_q.size() != 0) begin
            n_fail++; $display("FAIL local_neto_idle: got %0d bytes, required 0", neto_q.size());
        end
        n_checks++;
        if (tipo_cyc.size() == 0 || neti_cyc.size() == 0 || tipo_cyc[0] - neti_cyc[0] != 1) begin
            n_fail++; $display("FAIL local_latency: tipo/neti sample counts %0d/%0d, required latency 1", tipo_cyc.size(), neti_cyc.size());
        end
    endtask

    task automatic test_forward;
        logic [7:0] p[$];
        clear_mon();
        p = {8'h05, 8'h01, 8'hCC};
        drive_pkt(1'b0, p, 0);
        wait_drain(0, 3);
        n_checks++;
        if (neto_q.size() != 3 || pack8(neto_q) !== 64'h05_01CC) begin
            n_fail++; $display("FAIL fwd_neto: got %0d bytes %h, required 3 bytes 0501cc", neto_q.size(), pack8(neto_q));
        end
        n_checks++;
        if (tipo_q.size() != 0) begin
            n_fail++; $display("FAIL fwd_tipo_idle: got %0d bytes, required 0", tipo_q.size());
        end
        n_checks++;
        if (neto_cyc.size() == 0 || neti_cyc.size() == 0 || neto_cyc[0] - neti_cyc[0] != 1) begin
            n_fail++; $display("FAIL fwd_latency: neto/neti sample counts %0d/%0d, required latency 1", neto_cyc.size(), neti_cyc.size());
        end
    endtask

    task automatic test_contention;
        logic [7:0] pn[$];
        logic [7:0] pt[$];
        clear_mon();
        pn = {8'h05, 8'h03, 8'h11, 8'h22, 8'h33};
        pt = {8'h07, 8'h00};
        fork
            drive_pkt(1'b0, pn, 0);
            drive_pkt(1'b1, pt, 0);
        join
        wait_drain(0, 7);
        n_checks++;
        if (neto_q.size() != 7 || pack8(neto_q) !== 64'h0005_0311_2233_0700) begin
            n_fail++; $display("FAIL contention_order: got %0d bytes %h, required 7 bytes 05031122330700", neto_q.size(), pack8(neto_q));
        end
    endtask

    task automatic test_halt;
        logic [7:0] pt[$];
        logic [7:0] pn[$];
        int drop_cyc = 0;
        clear_mon();
        pt = {8'h09, 8'h00};
        pn = {8'h05, 8'h00};
        n_checks++;
        if (hreq_o !== 1'b0) begin
            n_fail++; $display("FAIL halt_pre: hreq_o=%b, required 0", hreq_o);
        end
        hreq_i = 1'b1;
        @(posedge uclock);
        #1;
        n_checks++;
        if (hreq_o !== 1'b1) begin
            n_fail++; $display("FAIL halt_hreq_o: hreq_o=%b, required 1", hreq_o);
        end
        fork
            drive_pkt(1'b1, pt, 0);
            begin
                repeat (5) @(posedge uclock);
                #1;
                n_checks++;
                if (neto_q.size() != 0 || tipi_cyc.size() != 0) begin
                    n_fail++; $display("FAIL halt_hold: neto=%0d tipi_acc=%0d, required 0/0", neto_q.size(), tipi_cyc.size());
                end
                drive_pkt(1'b0, pn, 0);
                repeat (3) @(posedge uclock);
                #1;
                n_checks++;
                if (neto_q.size() != 2 || pack8(neto_q) !== 64'h0500) begin
                    n_fail++; $display("FAIL halt_passthru: got %0d bytes %h, required 2 bytes 0500", neto_q.size(), pack8(neto_q));
                end
                hreq_i = 1'b0;
                drop_cyc = cyc;
            end
        join
        wait_drain(0, 4);
        n_checks++;
        if (neto_q.size() != 4 || pack8(neto_q) !== 64'h0500_0900) begin
            n_fail++; $display("FAIL halt_release: got %0d bytes %h, required 4 bytes 05000900", neto_q.size(), pack8(neto_q));
        end
        n_checks++;
        if (tipi_cyc.size() == 0 || tipi_cyc[0] <= drop_cyc) begin
            n_fail++; $display("FAIL halt_start: tipi accepted %0d bytes, first not after release cycle %0d", tipi_cyc.size(), drop_cyc);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp[$];
        clear_mon();
        tipo_ready = 1'b0;
        fork
            for (int k = 0; k < 4; k++) begin
                logic [7:0] p[$];
                p = {8'h01, 8'h01, 8'(8'hA0 + k)};
                foreach (p[j]) exp.push_back(p[j]);
                drive_pkt(1'b0, p, 0);
            end
            begin
                repeat (15) @(posedge uclock);
                @(negedge uclock);
                n_checks++;
                if (neti_ready !== 1'b0 || hreq_o !== 1'b1 || tipo_q.size() != 0) begin
                    n_fail++; $display("FAIL bp_stall: neti_ready=%b hreq_o=%b tipo=%0d, required 0/1/0", neti_ready, hreq_o, tipo_q.size());
                end
                @(posedge uclock);
                #1 tipo_ready = 1'b1;
            end
        join
        wait_drain(12, 0);
        n_checks++;
        if (tipo_q.size() != exp.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d bytes, required %0d", tipo_q.size(), exp.size());
        end
        for (int i = 0; i < tipo_q.size() && i < exp.size(); i++) begin
            n_checks++;
            if (tipo_q[i] !== exp[i]) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h, required %h", i, tipo_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] p[$];
        clear_mon();
        p = {8'h01, 8'h04, 8'h11, 8'h22};
        drive_pkt(1'b0, p, 0);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({neti_ready, tipi_ready, neto_valid, tipo_valid, hreq_o} !== 5'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b, required 00000", {neti_ready, tipi_ready, neto_valid, tipo_valid, hreq_o});
        end
        repeat (2) @(posedge uclock);
        #2 reset = 1'b1;
        @(posedge uclock);
        #1;
        clear_mon();
        p = {8'h01, 8'h00};
        drive_pkt(1'b0, p, 0);
        wait_drain(2, 0);
        n_checks++;
        if (tipo_q.size() != 2 || pack8(tipo_q) !== 64'h0100) begin
            n_fail++; $display("FAIL midreset_next: got %0d bytes %h, required 2 bytes 0100", tipo_q.size(), pack8(tipo_q));
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_tipo[$];
        logic [7:0] exp_nn[$];
        logic [7:0] exp_nt[$];
        int pos = 0;
        clear_mon();
        rnd_done = 1'b0;
        fork
            begin
                fork
                    for (int k = 0; k < 30; k++) begin
                        logic [7:0] p[$];
                        logic [7:0] d;
                        int n;
                        n = int'($urandom_range(2, 0));
                        d = (n == 0) ? ADDR : (n == 1) ? 8'hFF : 8'($urandom_range(255, 0));
                        n = int'($urandom_range(5, 0));
                        p = {d, 8'(n)};
                        for (int j = 0; j < n; j++) p.push_back(8'($urandom_range(255, 0)));
`ifdef TBLINK_RPC_EP_BCAST_EN
                        if (d == 8'hFF) foreach (p[j]) exp_tipo.push_back(p[j]);
                        if (d != ADDR) foreach (p[j]) exp_nn.push_back(p[j]);
`else
                        if (d == ADDR) foreach (p[j]) exp_tipo.push_back(p[j]);
                        else foreach (p[j]) exp_nn.push_back(p[j]);
`endif
                        drive_pkt(1'b0, p, 2);
                    end
                    for (int k = 0; k < 20; k++) begin
                        logic [7:0] p[$];
                        int n;
                        n = int'($urandom_range(4, 0));
                        p = {8'($urandom_range(255, 0)), 8'(n)};
                        for (int j = 0; j < n; j++) p.push_back(8'($urandom_range(255, 0)));
                        foreach (p[j]) exp_nt.push_back(p[j]);
                        drive_pkt(1'b1, p, 3);
                    end
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tipo_ready = ($urandom_range(3, 0) != 0);
                    neto_ready = ($urandom_range(3, 0) != 0);
                    @(posedge uclock);
                    #1;
                end
                tipo_ready = 1'b1;
                neto_ready = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    hreq_i = ($urandom_range(7, 0) == 0);
                    repeat ($urandom_range(4, 1)) @(posedge uclock);
                    #1;
                end
                hreq_i = 1'b0;
            end
        join
        wait_drain(exp_tipo.size(), exp_nn.size() + exp_nt.size());
        n_checks++;
        if (tipo_q.size() != exp_tipo.size()) begin
            n_fail++; $display("FAIL rnd_tipo_count: got %0d bytes, required %0d", tipo_q.size(), exp_tipo.size());
        end
        for (int i = 0; i < tipo_q.size() && i < exp_tipo.size(); i++) begin
            n_checks++;
            if (tipo_q[i] !== exp_tipo[i]) begin
                n_fail++; $display("FAIL rnd_tipo_byte%0d: got %h, required %h", i, tipo_q[i], exp_tipo[i]);
            end
        end
        // Each neto packet must be the next whole packet of one of the two sources.
        while (pos + 1 < neto_q.size()) begin
            int  plen;
            bit  m_n;
            bit  m_t;
            plen = int'(neto_q[pos + 1]) + 2;
            m_n = (exp_nn.size() >= plen) && (pos + plen <= neto_q.size());
            m_t = (exp_nt.size() >= plen) && (pos + plen <= neto_q.size());
            for (int j = 0; j < plen && (m_n || m_t); j++) begin
                if (m_n && exp_nn[j] !== neto_q[pos + j]) m_n = 1'b0;
                if (m_t && exp_nt[j] !== neto_q[pos + j]) m_t = 1'b0;
            end
            n_checks++;
            if (m_n) begin
                repeat (plen) void'(exp_nn.pop_front());
            end else if (m_t) begin
                repeat (plen) void'(exp_nt.pop_front());
            end else begin
                n_fail++; $display("FAIL rnd_neto_pkt@%0d: dst %h len %0d matches no pending packet", pos, neto_q[pos], plen - 2);
                break;
            end
            pos += plen;
        end
        n_checks++;
        if (exp_nn.size() != 0 || exp_nt.size() != 0 || pos != neto_q.size()) begin
            n_fail++; $display("FAIL rnd_neto_left: pending net=%0d tip=%0d parsed %0d of %0d, required all consumed",
                               exp_nn.size(), exp_nt.size(), pos, neto_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_local();
        test_forward();
        test_contention();
        test_halt();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tblink_rpc_ep.md
TBLINK_RPC_EP -- requirements
Module: tblink_rpc_ep

Interface
REQ-001 SHALL have parameter ADDR, default 0, 8-bit network address of this endpoint.
REQ-002 SHALL have port uclock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port hreq_i  input  1  halt request from upstream endpoint.
REQ-005 SHALL have port hreq_o  output  1  halt request to downstream endpoint.
REQ-006 SHALL have ports neti_dat/neti_valid  input  8/1, and neti_ready  output  1: ready/valid network ingress.
REQ-007 SHALL have ports neto_dat/neto_valid  output  8/1, and neto_ready  input  1: ready/valid network egress.
REQ-008 SHALL have ports tipo_dat/tipo_valid  output  8/1, and tipo_ready  input  1: ready/valid local delivery to the TIP.
REQ-009 SHALL have ports tipi_dat/tipi_valid  input  8/1, and tipi_ready  output  1: ready/valid local injection from the TIP.

Function
REQ-010 Packet format SHALL be: byte0 destination address, byte1 payload length N (0..255), then N payload bytes; total N+2 bytes.
REQ-011 A byte SHALL transfer only in a cycle where valid and ready are both 1; valid, once raised, SHALL stay high with stable dat until accepted.
REQ-012 Ingress packets with byte0 == ADDR SHALL be delivered whole (header included) on tipo, in order.
REQ-013 Ingress packets with byte0 != ADDR SHALL be forwarded unchanged on neto.
REQ-014 Packets from tipi SHALL be forwarded unchanged on neto.
REQ-015 The routing decision SHALL be made on byte0, and the packet SHALL then route as a unit until its last byte.
REQ-016 Ingress-to-output latency SHALL be 1 cycle: a byte accepted on neti in cycle T SHALL be valid on its output at T+1.
REQ-017 Each output SHALL have a 2-entry skid buffer, so full throughput of 1 byte/cycle is sustained.
REQ-018 neto arbitration SHALL be packet-granular: never interleave bytes of two packets.
REQ-019 When both sources request neto at a packet boundary in the same cycle, the pass-through (neti) source SHALL win.
REQ-020 A tipi packet SHALL be granted after at most one pass-through packet, giving alternating fairness.
REQ-021 A length byte of 0 SHALL yield a 2-byte packet; the state machine SHALL return to the header state after byte1.
REQ-022 While hreq_i is 1, no new tipi packet SHALL start on neto; a packet in progress SHALL complete.
REQ-023 While hreq_i is 1, pass-through traffic SHALL continue.
REQ-024 hreq_o SHALL be registered: hreq_o = hreq_i OR (tipo_valid AND NOT tipo_ready for 2 or more consecutive cycles).
REQ-025 Receive state machine SHALL have states HDR_DST, HDR_LEN, PAYLOAD, with a down-counter loaded from the length byte.
REQ-026 The receive state machine SHALL transition HDR_DST->HDR_LEN->PAYLOAD, or ->HDR_DST when the count is 0.
REQ-027 The tipi path SHALL use an identical, independent state machine for packet-boundary tracking.

Reset
REQ-028 While reset=0, all *_valid outputs, neti_ready, tipi_ready and hreq_o SHALL be 0.
REQ-029 Reset SHALL clear skid buffers, counters and arbitration state, and put all FSMs in HDR_DST.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet; after release, the next ingress byte SHALL be treated as byte0.
REQ-031 Ready outputs SHALL go high no earlier than the first clock edge after reset deasserts.

Configuration
REQ-032 With TBLINK_RPC_EP_BCAST_EN defined, byte0 == 8'hFF SHALL be delivered on tipo and forwarded on neto.
REQ-033 Under TBLINK_RPC_EP_BCAST_EN, a broadcast byte SHALL be accepted on neti only when both destinations accept it.
REQ-034 Without TBLINK_RPC_EP_BCAST_EN, 8'hFF SHALL be an ordinary address.

Structure
REQ-035 Package tblink_rpc_ep_pkg SHALL hold the FSM state enum, the header byte offsets, and constant BCAST_ADDR=8'hFF.
REQ-036 The per-stream header/length tracker SHALL be sub-module tblink_rpc_ep_pkt_trk, instantiated for the neti and tipi streams.

Verification
REQ-037 ADDR=1; neti packet {01,02,AA,BB} -> tipo carries {01,02,AA,BB}, neto idle.
REQ-038 neti packet {05,01,CC} -> neto carries {05,01,CC} unchanged, tipo idle, first byte on neto 1 cycle after acceptance.
REQ-039 Send {05,03,..} on neti and {07,00} on tipi, both starting the same cycle -> neto carries the whole neti packet, then {07,00}, never interleaved.
REQ-040 With hreq_i=1, drive tipi {09,00} -> tipi packet held; it starts on neto after hreq_i drops; hreq_o=1 one cycle after hreq_i rises.
REQ-041 Hold tipo_ready=0 while sending 4 local packets -> neti_ready eventually 0, no loss, hreq_o=1; release -> all bytes delivered in order.
REQ-042 Assert reset mid-payload of {01,04,..} -> outputs 0; after release, {01,00} is delivered intact on tipo.
